// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Purpose:
//   Reader-side consumer for the FIFO read port (re/empty/rdata). Pops one
//   byte at a time and serialises it as an 8N1 UART frame (start bit, data
//   LSB first, stop bit) on the tx line. The FIFO only presents rdata while
//   re && !empty, so the byte is captured in the same cycle re is asserted.
//
// Optional feature:
//   `define FIFO_UART_TX_PARITY_EN inserts an even-parity bit between the last
//   data bit and the stop bit (frame becomes DATA_WIDTH+3 bit times). With the
//   macro undefined there is no PARITY state and no parity register.
//
// Parameters:
//   CLK_FREQ     system clock frequency in Hz
//   BAUD         line rate in bit/s
//   CLKS_PER_BIT clocks per UART bit (defaults to CLK_FREQ/BAUD, must be >= 2)
//   DATA_WIDTH   payload bits per frame (matches the FIFO data width)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active low
//   empty    in   FIFO empty flag
//   rdata    in   FIFO read data, valid only while re=1 and empty=0
//   re       out  FIFO pop, combinational, one cycle per byte
//   tx       out  serial line, registered, idle high
//   tx_busy  out  high while a frame is in progress
//   tx_done  out  one-clock pulse after the stop bit completes
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  re,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic [IDX_W-1:0]        idx_q,   idx_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    tx_q,    tx_d;
    logic                    done_q,  done_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                    par_q,   par_d;
`endif

    logic bit_tick;

    assign bit_tick = (cnt_q == CNT_LAST);

    // The pop is gated by rst so that no byte is lost from the FIFO while the
    // block is held in reset, even though the state register already reads IDLE.
    assign re      = rst && (state_q == S_IDLE) && !empty;
    assign tx      = tx_q;
    assign tx_busy = (state_q != S_IDLE);
    assign tx_done = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        // Free-running bit timer in every non-IDLE state; it wraps on bit_tick
        // so each state's exit lines up with the next bit boundary.
        if (state_q != S_IDLE) begin
            cnt_d = bit_tick ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (re) begin
                    // rdata is only valid in this cycle, so latch it now.
                    shreg_d = rdata;
                    state_d = S_START;
                    tx_d    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
                    par_d   = ^rdata;
`endif
                end
            end

            S_START: begin
                if (bit_tick) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                end
            end

            S_DATA: begin
                if (bit_tick) begin
                    if (idx_q != IDX_LAST) begin
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shreg_d[0];
                    end else begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (bit_tick) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Reset drives the line high immediately, abandoning any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Bench for fifo_uart_tx with CLKS_PER_BIT=4. A queue models the FIFO; every
// pop pushes the expected byte into a scoreboard, and an independent monitor
// watches the line, rebuilds each frame from the framing rules and compares.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB    = DW + 2 + PAR;
    localparam int FRAME = NB * CPB;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          empty = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          re;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] fifo[$];
    logic [DW-1:0] exp_q[$];
    int            exp_re_q[$];
    int            re_log[$];
    int            start_log[$];
    int            done_log[$];
    int            re_cnt         = 0;
    int            done_cnt       = 0;
    int            frames_done    = 0;
    int            frames_aborted = 0;
    bit            mon_active     = 1'b0;

    fifo_uart_tx #(
        .CLK_FREQ    (100_000_000),
        .BAUD        (9600),
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .empty  (empty),
        .rdata  (rdata),
        .re     (re),
        .tx     (tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chkb(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chkv(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line level of bit slot i of a frame carrying byte b.
    function automatic logic frame_bit(input logic [DW-1:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= DW) return b[i-1];
        if (PAR != 0 && i == DW + 1) return ^b;
        return 1'b1;
    endfunction

    // FIFO model: pop takes effect just after the clock edge that saw re.
    initial forever begin
        logic re_seen;
        @(negedge clk);
        re_seen = re;
        if (re === 1'b1) begin
            re_cnt++;
            re_log.push_back(cyc);
            chkb("re_while_empty", empty, 1'b0);
            if (fifo.size() > 0) begin
                exp_q.push_back(fifo[0]);
                exp_re_q.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        if (re_seen === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
        empty = (fifo.size() == 0);
        rdata = empty ? '0 : fifo[0];
    end

    initial forever begin
        @(negedge clk);
        if (rst === 1'b1 && tx_done === 1'b1) done_cnt++;
    end

    // Line monitor: on each start bit it takes the next expected byte and
    // checks every clock of the frame, then the tx_done cycle that follows.
    initial begin : monitor
        logic          prev_tx;
        logic [DW-1:0] expb;
        logic [DW-1:0] got;
        int            st;
        int            rc;
        int            mism;
        bit            abort;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_tx = 1'b1;
                continue;
            end
            if (prev_tx === 1'b1 && tx === 1'b0) begin
                mon_active = 1'b1;
                st = cyc;
                start_log.push_back(st);
                if (exp_q.size() == 0) begin
                    chki("unexpected_frame", 1, 0);
                    expb = '0;
                    rc   = st - 1;
                end else begin
                    expb = exp_q.pop_front();
                    rc   = exp_re_q.pop_front();
                end
                chki("re_to_start", st - rc, 1);
                got   = '0;
                mism  = 0;
                abort = 1'b0;
                for (int b = 0; b < NB && !abort; b++) begin
                    for (int c = 0; c < CPB && !abort; c++) begin
                        if (b != 0 || c != 0) begin
                            @(negedge clk);
                            if (rst !== 1'b1) abort = 1'b1;
                        end
                        if (!abort) begin
                            if (tx !== frame_bit(expb, b)) mism++;
                            if (tx_done !== 1'b0 || tx_busy !== 1'b1) mism++;
                            if (c == CPB / 2 && b >= 1 && b <= DW) got[b-1] = tx;
                        end
                    end
                end
                if (!abort) begin
                    @(negedge clk);
                    if (rst !== 1'b1) abort = 1'b1;
                end
                if (abort) begin
                    frames_aborted++;
                end else begin
                    chkb("tx_done_pulse", tx_done, 1'b1);
                    chkb("idle_after_stop_busy", tx_busy, 1'b0);
                    chkb("idle_after_stop_tx", tx, 1'b1);
                    chki("frame_wave_mismatches", mism, 0);
                    chkv("frame_byte", got, expb);
                    done_log.push_back(cyc);
                    frames_done++;
                end
                mon_active = 1'b0;
            end
            prev_tx = tx;
        end
    end

    task automatic push(input logic [DW-1:0] b);
        @(posedge clk);
        #2;
        fifo.push_back(b);
        empty = 1'b0;
        rdata = fifo[0];
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n;
        n = 0;
        while (n < max_cyc && (fifo.size() != 0 || exp_q.size() != 0 ||
                               mon_active || tx_busy !== 1'b0)) begin
            @(negedge clk);
            n++;
        end
        chki({name, "_drain_timeout"}, (n >= max_cyc) ? 1 : 0, 0);
    endtask

    task automatic wait_busy(input int max_cyc, input string name);
        int n;
        n = 0;
        while (n < max_cyc && tx_busy !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chki({name, "_busy_timeout"}, (n >= max_cyc) ? 1 : 0, 0);
    endtask

    task automatic check_idle(input int ncyc, input string name);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chkv(name, {4'b0, tx, re, tx_busy, tx_done}, 8'h08);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int r0;
        int st;
        int d0;
        int a0;

        // Reset state, including re held low while a byte is waiting.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chkv("reset_outputs", {4'b0, tx, re, tx_busy, tx_done}, 8'h08);
        push(8'h5A);
        @(negedge clk);
        chkb("re_in_reset_nonempty", re, 1'b0);
        @(posedge clk);
        #2;
        fifo.delete();
        empty = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        check_idle(50, "idle_after_reset");

        // Single byte 0x55.
        r0 = re_cnt;
        push(8'h55);
        wait_drain(200, "t55");
        chki("t55_re_pulses", re_cnt - r0, 1);
        chki("t55_frame_len", done_log[$] - start_log[$], FRAME);

        // Three back-to-back bytes.
        start_log.delete();
        r0 = re_cnt;
        push(8'hA3);
        push(8'h0F);
        push(8'hFF);
        wait_drain(600, "t3");
        chki("t3_re_pulses", re_cnt - r0, 3);
        chki("t3_frames", start_log.size(), 3);
        for (int i = 1; i < start_log.size(); i++)
            chki("t3_start_spacing", start_log[i] - start_log[i-1], FRAME + 1);
        check_idle(10, "t3_idle_after");

        // Write arriving mid-frame is sent only after the current frame.
        done_log.delete();
        re_log.delete();
        push(8'h3C);
        wait_busy(20, "tmid");
        repeat (8) @(negedge clk);
        push(8'h81);
        wait_drain(400, "tmid");
        chki("tmid_pops", re_log.size(), 2);
        chki("tmid_frames", done_log.size(), 2);
        if (re_log.size() == 2 && done_log.size() >= 1)
            chki("tmid_second_pop_at_done", re_log[1], done_log[0]);

        // Reset asserted during data bit 3 of 0xC5.
        start_log.delete();
        a0 = frames_aborted;
        push(8'hC5);
        wait_busy(20, "trst");
        @(negedge clk);
        chki("trst_started", start_log.size(), 1);
        st = (start_log.size() > 0) ? start_log[0] : cyc;
        while (cyc < st + CPB * 4 + 1) @(negedge clk);
        chkb("trst_bit3_low", tx, 1'b0);
        d0 = done_cnt;
        #1;
        rst = 1'b0;
        #1;
        chkb("trst_async_tx_high", tx, 1'b1);
        chkb("trst_async_busy_low", tx_busy, 1'b0);
        repeat (5) @(negedge clk);
        chkb("trst_re_in_reset", re, 1'b0);
        rst = 1'b1;
        check_idle(30, "trst_idle_after");
        chki("trst_no_done", done_cnt - d0, 0);
        chki("trst_frame_abandoned", frames_aborted - a0, 1);
        chki("trst_no_pending", exp_q.size(), 0);

        // Parity-sensitive bytes: frame length differs with the parity build.
        push(8'h55);
        wait_drain(200, "tpar55");
        chki("tpar55_frame_len", done_log[$] - start_log[$], FRAME);
        push(8'h07);
        wait_drain(200, "tpar07");
        chki("tpar07_frame_len", done_log[$] - start_log[$], FRAME);

        // Random bytes with random gaps, including pushes mid-frame.
        r0 = re_cnt;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            push(8'($urandom));
        end
        wait_drain(2500, "trand");
        chki("trand_re_pulses", re_cnt - r0, 20);

        check_idle(5, "final_idle");
        chki("scoreboard_empty", exp_q.size(), 0);
        chki("done_pulse_count", done_cnt, frames_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
